// File: rtl/riscv_core_mux_nto1_pipe.sv
// riscv_core_mux_nto1_pipe
// N:1 data mux with a registered output and a valid/ready handshake. The output
// register is backed by a one-entry skid register, so the upstream ready is a
// plain flop output and back-pressure never drops or duplicates a beat.
// Beats whose select is out of range carry DEFAULT_VALUE and a sel_err flag.
module riscv_core_mux_nto1_pipe #(
  parameter int unsigned             DATA_WIDTH    = 64,
  parameter int unsigned             NUM_INPUTS    = 4,
  parameter logic [DATA_WIDTH-1:0]   DEFAULT_VALUE = '0,
  localparam int unsigned            SEL_WIDTH     = $clog2(NUM_INPUTS)
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_flush,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_inputs,
  input  logic [SEL_WIDTH-1:0]             i_sel,
  input  logic                             i_valid,
  output logic                             o_ready,
  output logic [DATA_WIDTH-1:0]            o_mux_out,
  output logic                             o_sel_err,
  output logic                             o_valid,
  input  logic                             i_ready
);

  // Buffer occupancy: EMPTY (nothing held), FULL (output reg only),
  // SKID (output reg and skid reg both hold a beat).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Data and its select-error flag always move as one unit.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } beat_t;

  state_e state_q, state_d;
  beat_t  out_q,   out_d;
  beat_t  skid_q,  skid_d;
  logic   rst_done_q, rst_done_d;

  beat_t  beat_in;
  logic   accept;
  logic   pop;

  // Select the incoming beat; any select that matches no input falls through to
  // DEFAULT_VALUE with the error flag set, which also keeps the slice in range.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    beat_in.data = DEFAULT_VALUE;
    beat_in.err  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (i_sel == SEL_WIDTH'(k)) begin
        beat_in.data = i_inputs[k*DATA_WIDTH +: DATA_WIDTH];
        beat_in.err  = 1'b0;
      end
    end
  end

  // Handshake decode. ready depends only on flops, so it never combinationally
  // follows i_ready or i_valid.
  always_comb begin
    o_ready = (state_q != ST_SKID) && rst_done_q;
    o_valid = (state_q != ST_EMPTY);
    accept  = i_valid && o_ready;
    pop     = o_valid && i_ready;
  end

  // Next-state and buffer update; flush wins over any same-cycle accept or pop.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    skid_d     = skid_q;
    rst_done_d = 1'b1;

    if (i_flush) begin
      state_d   = ST_EMPTY;
      out_d.err = 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            out_d   = beat_in;
          end
        end
        ST_FULL: begin
          if (accept && !pop) begin
            state_d = ST_SKID;
            skid_d  = beat_in;
          end else if (accept && pop) begin
            out_d   = beat_in;
          end else if (!accept && pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (pop) begin
            state_d = ST_FULL;
            out_d   = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State, buffer and reset-done registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: the data registers are reset as well so o_mux_out reads zero
    // immediately on reset instead of exposing a stale beat.
    if (!i_rst_n) begin
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      rst_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      rst_done_q <= rst_done_d;
    end
  end

  // Registered beat drives the outputs directly.
  always_comb begin
    o_mux_out = out_q.data;
    o_sel_err = out_q.err;
  end

endmodule

// File: tb/tb_riscv_core_mux_nto1_pipe.sv
// Self-checking bench for riscv_core_mux_nto1_pipe: one 4-input instance for
// latency, streaming, back-pressure, flush and async reset, and one 3-input
// instance with DEFAULT_VALUE=0xDEAD for out-of-range selects.
module tb_riscv_core_mux_nto1_pipe;

  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 4-input instance
  logic            flush4;
  logic [4*DW-1:0] in4;
  logic [1:0]      sel4;
  logic            valid4, ready4, err4, ovalid4, dready4;
  logic [DW-1:0]   mux4;

  // 3-input instance
  logic            flush3;
  logic [3*DW-1:0] in3;
  logic [1:0]      sel3;
  logic            valid3, ready3, err3, ovalid3, dready3;
  logic [DW-1:0]   mux3;

  riscv_core_mux_nto1_pipe #(
    .DATA_WIDTH(DW), .NUM_INPUTS(4), .DEFAULT_VALUE(64'h0)
  ) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush4), .i_inputs(in4),
    .i_sel(sel4), .i_valid(valid4), .o_ready(ready4), .o_mux_out(mux4),
    .o_sel_err(err4), .o_valid(ovalid4), .i_ready(dready4)
  );

  riscv_core_mux_nto1_pipe #(
    .DATA_WIDTH(DW), .NUM_INPUTS(3), .DEFAULT_VALUE(64'hDEAD)
  ) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush3), .i_inputs(in3),
    .i_sel(sel3), .i_valid(valid3), .o_ready(ready3), .o_mux_out(mux3),
    .o_sel_err(err3), .o_valid(ovalid3), .i_ready(dready3)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Hand-computed expected beats for each instance.
  function automatic exp_t model4(input logic [1:0] s);
    case (s)
      2'd0:    return {64'h11, 1'b0};
      2'd1:    return {64'h22, 1'b0};
      2'd2:    return {64'h33, 1'b0};
      default: return {64'h44, 1'b0};
    endcase
  endfunction

  function automatic exp_t model3(input logic [1:0] s);
    case (s)
      2'd0:    return {64'h11, 1'b0};
      2'd1:    return {64'h22, 1'b0};
      2'd2:    return {64'h33, 1'b0};
      default: return {64'hDEAD, 1'b1};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat for one cycle; record it as expected only if it is accepted.
  task automatic send4(input logic [1:0] s);
    sel4   = s;
    valid4 = 1'b1;
    if (ready4 && !flush4) q4.push_back(model4(s));
    tick();
  endtask

  task automatic send3(input logic [1:0] s);
    sel3   = s;
    valid3 = 1'b1;
    if (ready3 && !flush3) q3.push_back(model3(s));
    tick();
  endtask

  // Monitors: a beat is transferred at the next rising edge when valid and
  // ready are both high; sample at the falling edge where inputs are stable.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush4 && ovalid4 && dready4) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon4_unexpected: got beat 0x%0h, expected no beat", mux4);
      end else begin
        e = q4.pop_front();
        check("mon4_data", mux4, e.data);
        check("mon4_err", {63'b0, err4}, {63'b0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !flush3 && ovalid3 && dready3) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon3_unexpected: got beat 0x%0h, expected no beat", mux3);
      end else begin
        e = q3.pop_front();
        check("mon3_data", mux3, e.data);
        check("mon3_err", {63'b0, err3}, {63'b0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    flush4  = 1'b0; sel4 = '0; valid4 = 1'b0; dready4 = 1'b0;
    flush3  = 1'b0; sel3 = '0; valid3 = 1'b0; dready3 = 1'b0;
    in4     = {64'h44, 64'h33, 64'h22, 64'h11};
    in3     = {64'h33, 64'h22, 64'h11};

    // Reset state
    #1;
    check("rst_valid", {63'b0, ovalid4}, 64'd0);
    check("rst_data",  mux4, 64'd0);
    check("rst_err",   {63'b0, err4}, 64'd0);
    check("rst_ready", {63'b0, ready4}, 64'd0);
    tick();
    check("rst_ready_held", {63'b0, ready4}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", {63'b0, ready4}, 64'd0);
    tick();
    check("ready_after_edge", {63'b0, ready4}, 64'd1);

    // Latency: sel=2 -> 0x33 one cycle later
    dready4 = 1'b1;
    send4(2'd2);
    valid4 = 1'b0;
    check("lat_valid", {63'b0, ovalid4}, 64'd1);
    check("lat_data",  mux4, 64'h33);

    // Streaming sel 0..3 back-to-back
    for (int s = 0; s < 4; s++) begin
      send4(2'(s));
      check("stream_ready", {63'b0, ready4}, 64'd1);
      check("stream_valid", {63'b0, ovalid4}, 64'd1);
    end
    valid4 = 1'b0;
    tick();

    // Back-pressure: fill output and skid, hold, then drain
    dready4 = 1'b0;
    send4(2'd1);
    send4(2'd3);
    valid4 = 1'b0;
    check("bp_ready", {63'b0, ready4}, 64'd0);
    check("bp_valid", {63'b0, ovalid4}, 64'd1);
    check("bp_data",  mux4, 64'h22);
    tick();
    tick();
    check("bp_data_stable", mux4, 64'h22);
    dready4 = 1'b1;
    tick();
    tick();
    tick();
    check("bp_drained", {63'b0, ovalid4}, 64'd0);

    // Flush from FULL with an accepted-looking beat in the same cycle
    dready4 = 1'b0;
    send4(2'd0);
    sel4 = 2'd1; valid4 = 1'b1; flush4 = 1'b1;
    tick();
    flush4 = 1'b0; valid4 = 1'b0;
    q4.delete();
    check("flushf_valid", {63'b0, ovalid4}, 64'd0);
    check("flushf_ready", {63'b0, ready4}, 64'd1);

    // Flush from SKID with i_valid high
    send4(2'd0);
    send4(2'd1);
    check("skid_ready", {63'b0, ready4}, 64'd0);
    sel4 = 2'd2; valid4 = 1'b1; flush4 = 1'b1;
    tick();
    flush4 = 1'b0; valid4 = 1'b0;
    q4.delete();
    check("flushs_valid", {63'b0, ovalid4}, 64'd0);
    check("flushs_ready", {63'b0, ready4}, 64'd1);
    check("flushs_err",   {63'b0, err4}, 64'd0);
    dready4 = 1'b1;
    tick();
    tick();
    tick();
    check("flush_no_beat", {63'b0, ovalid4}, 64'd0);

    // Out-of-range select on the 3-input instance
    dready3 = 1'b1;
    send3(2'd0);
    send3(2'd3);
    check("oor_data", mux3, 64'hDEAD);
    check("oor_err",  {63'b0, err3}, 64'd1);
    send3(2'd1);
    check("oor_next_data", mux3, 64'h22);
    check("oor_next_err",  {63'b0, err3}, 64'd0);
    valid3 = 1'b0;
    tick();

    // Flush clears a held sel_err
    dready3 = 1'b0;
    send3(2'd3);
    valid3 = 1'b0;
    check("oor_held_err", {63'b0, err3}, 64'd1);
    flush3 = 1'b1;
    tick();
    flush3 = 1'b0;
    q3.delete();
    check("flush_err_clr", {63'b0, err3}, 64'd0);
    check("flush3_valid",  {63'b0, ovalid3}, 64'd0);

    // Async reset mid-stream in SKID
    dready4 = 1'b0;
    send4(2'd3);
    send4(2'd2);
    valid4 = 1'b0;
    check("pre_arst_data", mux4, 64'h44);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'b0, ovalid4}, 64'd0);
    check("arst_data",  mux4, 64'd0);
    check("arst_ready", {63'b0, ready4}, 64'd0);
    q4.delete();
    tick();
    @(negedge clk);
    rst_n   = 1'b1;
    dready4 = 1'b1;
    tick();
    tick();
    tick();
    check("arst_no_beat", {63'b0, ovalid4}, 64'd0);
    check("arst_ready_back", {63'b0, ready4}, 64'd1);

    check("q4_empty", 64'(q4.size()), 64'd0);
    check("q3_empty", 64'(q3.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
